// File: rtl/hline_pkg.sv
// Shared constants, FSM encoding and the restoring-divide step for the hline span setup stage.
package hline_pkg;

    localparam int DIV_ITERS = 32;
    localparam int BPP_SHIFT = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_DIV   = 3'd2,
        ST_ISSUE = 3'd3,
        ST_WAIT  = 3'd4
    } state_e;

    // One restoring step: returns {next_remainder, next_quotient_shift_register}.
    function automatic logic [63:0] div_step(input logic [31:0] rem,
                                             input logic [31:0] quo,
                                             input logic [31:0] den);
        logic [32:0] sh;
        logic [32:0] diff;
        sh   = {rem, quo[31]};
        diff = sh - {1'b0, den};
        if (!diff[32]) begin
            div_step = {diff[31:0], quo[30:0], 1'b1};
        end else begin
            div_step = {sh[31:0], quo[30:0], 1'b0};
        end
    endfunction

endpackage

// File: rtl/hline_div_seq.sv
// Sequential 32/32 unsigned restoring divider; the first quotient bit is resolved on the start cycle
// so done_o pulses exactly ITERS cycles after start_i.
module hline_div_seq
    import hline_pkg::*;
#(
    parameter int ITERS = DIV_ITERS
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic        start_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    output logic        done_o,
    output logic [31:0] quot_o,
    output logic [31:0] rem_o
);

    localparam int CW = $clog2(ITERS + 1);
    localparam logic [CW-1:0] LAST = CW'(ITERS - 1);

    logic [31:0]   rem_q, rem_d, quo_q, quo_d, den_q, den_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d, done_q, done_d;
    logic [31:0]   step_rem_s, step_quo_s, step_den_s;
    logic [63:0]   step_s;

    // Iteration control: load and first step on start, then one step per cycle.
    always_comb begin
        rem_d  = rem_q;
        quo_d  = quo_q;
        den_d  = den_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = 1'b0;
        if (start_i) begin
            step_rem_s = 32'd0;
            step_quo_s = dividend_i;
            step_den_s = divisor_i;
        end else begin
            step_rem_s = rem_q;
            step_quo_s = quo_q;
            step_den_s = den_q;
        end
        step_s = div_step(step_rem_s, step_quo_s, step_den_s);
        if (start_i) begin
            rem_d  = step_s[63:32];
            quo_d  = step_s[31:0];
            den_d  = divisor_i;
            cnt_d  = CW'(1);
            busy_d = 1'b1;
        end else if (busy_q) begin
            rem_d = step_s[63:32];
            quo_d = step_s[31:0];
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end else begin
                busy_d = 1'b1;
            end
        end else begin
            busy_d = 1'b0;
        end
    end

    // Divider state registers.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            rem_q  <= 32'd0;
            quo_q  <= 32'd0;
            den_q  <= 32'd0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            den_q  <= den_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign done_o = done_q;
    assign quot_o = quo_q;
    assign rem_o  = rem_q;

endmodule

// File: rtl/hline_setup.sv
// Horizontal span setup: orders endpoints, computes addresses, length and z slope,
// then launches the line FSM and waits for its done.
module hline_setup
    import hline_pkg::*;
(
    input  logic        clk,
    input  logic        nreset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [15:0] x1,
    input  logic [15:0] x2,
    input  logic [15:0] y,
    input  logic [31:0] z1,
    input  logic [31:0] z2,
    input  logic [31:0] rgbx,
    input  logic [31:0] fb_base,
    input  logic [31:0] zb_base,
    input  logic [15:0] stride,
    output logic        busy,
    output logic        ln_start,
    output logic [31:0] ln_fb_addr,
    output logic [31:0] ln_zbuff_addr,
    output logic [31:0] ln_dx,
    output logic [31:0] ln_slope,
    output logic [31:0] ln_z1,
    output logic [31:0] ln_rem,
    output logic [31:0] ln_err,
    output logic [31:0] ln_rgbx,
    input  logic        ln_done
);

    state_e      state_q, state_d;
    logic [15:0] xl_q, xl_d, xr_q, xr_d, y_q, y_d, stride_q, stride_d;
    logic [31:0] zl_q, zl_d, zr_q, zr_d, rgbx_q, rgbx_d, fb_q, fb_d, zb_q, zb_d;
    logic        sign_q, sign_d;
    logic [31:0] fb_addr_q, fb_addr_d, zb_addr_q, zb_addr_d, dx_q, dx_d;
    logic [31:0] slope_q, slope_d, z1_q, z1_d, rem_q, rem_d, col_q, col_d;

    logic [15:0] dx_s;
    logic [32:0] dz_s;
    logic [31:0] dz_mag_s, prod_s, offset_s;
    logic        div_start_s, div_done_s;
    logic [31:0] div_quo_s, div_rem_s;

    hline_div_seq #(.ITERS(DIV_ITERS)) u_div (
        .clk       (clk),
        .nreset    (nreset),
        .start_i   (div_start_s),
        .dividend_i(dz_mag_s),
        .divisor_i ({16'd0, dx_s}),
        .done_o    (div_done_s),
        .quot_o    (div_quo_s),
        .rem_o     (div_rem_s)
    );

    // Next-state and datapath: command capture, setup arithmetic, divider handoff.
    always_comb begin
        state_d     = state_q;
        xl_d        = xl_q;
        xr_d        = xr_q;
        y_d         = y_q;
        stride_d    = stride_q;
        zl_d        = zl_q;
        zr_d        = zr_q;
        rgbx_d      = rgbx_q;
        fb_d        = fb_q;
        zb_d        = zb_q;
        sign_d      = sign_q;
        fb_addr_d   = fb_addr_q;
        zb_addr_d   = zb_addr_q;
        dx_d        = dx_q;
        slope_d     = slope_q;
        z1_d        = z1_q;
        rem_d       = rem_q;
        col_d       = col_q;
        div_start_s = 1'b0;

        dx_s     = xr_q - xl_q;
        dz_s     = {1'b0, zr_q} - {1'b0, zl_q};
        // |dz| never exceeds 2^32-1, so the low word of the negation is exact.
        dz_mag_s = dz_s[32] ? (32'd0 - dz_s[31:0]) : dz_s[31:0];
        prod_s   = {16'd0, y_q} * {16'd0, stride_q};
        offset_s = (prod_s + {16'd0, xl_q}) << BPP_SHIFT;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (x1 <= x2) begin
                        xl_d = x1;
                        xr_d = x2;
                        zl_d = z1;
                        zr_d = z2;
                    end else begin
                        xl_d = x2;
                        xr_d = x1;
                        zl_d = z2;
                        zr_d = z1;
                    end
                    y_d      = y;
                    stride_d = stride;
                    rgbx_d   = rgbx;
                    fb_d     = fb_base;
                    zb_d     = zb_base;
                    state_d  = ST_ADDR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ADDR: begin
                dx_d      = {16'd0, dx_s};
                sign_d    = dz_s[32];
                fb_addr_d = fb_q + offset_s;
                zb_addr_d = zb_q + offset_s;
                z1_d      = zl_q;
                col_d     = rgbx_q;
                if (dx_s == 16'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    div_start_s = 1'b1;
                    state_d     = ST_DIV;
                end
            end
            ST_DIV: begin
                if (div_done_s) begin
                    slope_d = sign_q ? (32'd0 - div_quo_s) : div_quo_s;
                    rem_d   = div_rem_s;
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_DIV;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (ln_done) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, latched command and launch parameter registers.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q   <= ST_IDLE;
            xl_q      <= 16'd0;
            xr_q      <= 16'd0;
            y_q       <= 16'd0;
            stride_q  <= 16'd0;
            zl_q      <= 32'd0;
            zr_q      <= 32'd0;
            rgbx_q    <= 32'd0;
            fb_q      <= 32'd0;
            zb_q      <= 32'd0;
            sign_q    <= 1'b0;
            fb_addr_q <= 32'd0;
            zb_addr_q <= 32'd0;
            dx_q      <= 32'd0;
            slope_q   <= 32'd0;
            z1_q      <= 32'd0;
            rem_q     <= 32'd0;
            col_q     <= 32'd0;
        end else begin
            state_q   <= state_d;
            xl_q      <= xl_d;
            xr_q      <= xr_d;
            y_q       <= y_d;
            stride_q  <= stride_d;
            zl_q      <= zl_d;
            zr_q      <= zr_d;
            rgbx_q    <= rgbx_d;
            fb_q      <= fb_d;
            zb_q      <= zb_d;
            sign_q    <= sign_d;
            fb_addr_q <= fb_addr_d;
            zb_addr_q <= zb_addr_d;
            dx_q      <= dx_d;
            slope_q   <= slope_d;
            z1_q      <= z1_d;
            rem_q     <= rem_d;
            col_q     <= col_d;
        end
    end

    // cmd_ready is held low while reset is asserted even though the FSM sits in IDLE.
    assign cmd_ready     = (state_q == ST_IDLE) & nreset;
    assign busy          = (state_q != ST_IDLE);
    assign ln_start      = (state_q == ST_ISSUE);
    assign ln_fb_addr    = fb_addr_q;
    assign ln_zbuff_addr = zb_addr_q;
    assign ln_dx         = dx_q;
    assign ln_slope      = slope_q;
    assign ln_z1         = z1_q;
    assign ln_rem        = rem_q;
    assign ln_err        = 32'd0;
    assign ln_rgbx       = col_q;

endmodule

// File: tb/tb_hline_setup.sv
// Self-checking bench for hline_setup: directed plan cases plus randomized spans against a behavioural model.
module tb_hline_setup;

    logic        clk = 1'b0;
    logic        nreset, cmd_valid, cmd_ready, busy, ln_start, ln_done;
    logic [15:0] x1, x2, y, stride;
    logic [31:0] z1, z2, rgbx, fb_base, zb_base;
    logic [31:0] ln_fb_addr, ln_zbuff_addr, ln_dx, ln_slope, ln_z1, ln_rem, ln_err, ln_rgbx;
    logic [255:0] obs;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hline_setup dut (
        .clk(clk), .nreset(nreset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .x1(x1), .x2(x2), .y(y), .z1(z1), .z2(z2), .rgbx(rgbx),
        .fb_base(fb_base), .zb_base(zb_base), .stride(stride),
        .busy(busy), .ln_start(ln_start),
        .ln_fb_addr(ln_fb_addr), .ln_zbuff_addr(ln_zbuff_addr), .ln_dx(ln_dx),
        .ln_slope(ln_slope), .ln_z1(ln_z1), .ln_rem(ln_rem), .ln_err(ln_err),
        .ln_rgbx(ln_rgbx), .ln_done(ln_done)
    );

    assign obs = {ln_dx, ln_slope, ln_rem, ln_err, ln_z1, ln_fb_addr, ln_zbuff_addr, ln_rgbx};

    // Reference: span rules in plain integer arithmetic; returns the expected obs vector.
    function automatic logic [255:0] model(input longint ax1, ax2, ay, astr, az1, az2, acol, afb, azb);
        longint xl, xr, zl, zr, dx, dz, mag, off;
        logic [31:0] slope, rem;
        if (ax1 <= ax2) begin xl = ax1; xr = ax2; zl = az1; zr = az2; end
        else            begin xl = ax2; xr = ax1; zl = az2; zr = az1; end
        dx  = xr - xl;
        dz  = zr - zl;
        mag = (dz < 0) ? -dz : dz;
        slope = 32'd0;
        rem   = 32'd0;
        if (dx != 0) begin
            slope = 32'(dz / dx);
            rem   = 32'(mag % dx);
        end
        off = (ay * astr + xl) * 4;
        return {32'(dx), slope, rem, 32'd0, 32'(zl), 32'(afb + off), 32'(azb + off), 32'(acol)};
    endfunction

    // Present the current command for one handshake; report the cycle of ln_start (-1 if none within 60).
    task automatic launch(output int start_cyc);
        @(negedge clk);
        cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        start_cyc = -1;
        for (int k = 1; k <= 60; k++) begin
            if (k > 1) @(negedge clk);
            if (ln_start === 1'b1) begin
                start_cyc = k;
                break;
            end
        end
    endtask

    task automatic finish_span;
        @(negedge clk);
        ln_done = 1'b1;
        @(negedge clk);
        ln_done = 1'b0;
    endtask

    task automatic set_cmd(input logic [15:0] a1, a2, ay, astr, input logic [31:0] b1, b2, col, fb, zb);
        x1 = a1; x2 = a2; y = ay; stride = astr; z1 = b1; z2 = b2; rgbx = col; fb_base = fb; zb_base = zb;
    endtask

    task automatic test_reset;
        nreset = 1'b1; cmd_valid = 1'b0; ln_done = 1'b0;
        set_cmd(16'd0, 16'd0, 16'd0, 16'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        #2 nreset = 1'b0;
        #3;
        checks++;
        if ({cmd_ready, busy, ln_start, obs} !== 259'd0) begin
            failures++;
            $display("FAIL reset_outputs: got ready=%0b busy=%0b start=%0b obs=%h, want all 0",
                     cmd_ready, busy, ln_start, obs);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        nreset = 1'b1;
        #1;
        checks++;
        if ({cmd_ready, busy} !== 2'b10) begin
            failures++;
            $display("FAIL reset_release: got ready=%0b busy=%0b, want ready=1 busy=0", cmd_ready, busy);
        end
    endtask

    // Plan cases 1-3 with hand-derived expectations.
    task automatic test_directed;
        logic [15:0]  tx1 [3] = '{16'd10, 16'd20, 16'd0};
        logic [15:0]  tx2 [3] = '{16'd20, 16'd10, 16'd3};
        logic [31:0]  tz1 [3] = '{32'd100, 32'd150, 32'd10};
        logic [31:0]  tz2 [3] = '{32'd150, 32'd100, 32'd0};
        logic [255:0] want [3];
        int sc;
        want[0] = {32'd10, 32'd5, 32'd0, 32'd0, 32'd100, 32'h10003228, 32'h20003228, 32'hAABBCCDD};
        want[1] = want[0];
        want[2] = {32'd3, 32'hFFFFFFFD, 32'd1, 32'd0, 32'd10, 32'h10003200, 32'h20003200, 32'hAABBCCDD};
        for (int i = 0; i < 3; i++) begin
            set_cmd(tx1[i], tx2[i], 16'd5, 16'd640, tz1[i], tz2[i], 32'hAABBCCDD, 32'h10000000, 32'h20000000);
            launch(sc);
            checks++;
            if (sc != 34) begin
                failures++;
                $display("FAIL directed%0d_start_cycle: got %0d, want 34", i + 1, sc);
            end
            checks++;
            if (obs !== want[i]) begin
                failures++;
                $display("FAIL directed%0d_outputs: got %h, want %h", i + 1, obs, want[i]);
            end
            @(negedge clk);
            checks++;
            if ({ln_start, busy} !== 2'b01) begin
                failures++;
                $display("FAIL directed%0d_pulse_width: got start=%0b busy=%0b, want start=0 busy=1",
                         i + 1, ln_start, busy);
            end
            finish_span();
        end
    endtask

    task automatic test_zero_length;
        int seen = 0;
        set_cmd(16'd7, 16'd7, 16'd3, 16'd100, 32'd50, 32'd900, 32'h01020304, 32'h0, 32'h0);
        @(negedge clk);
        cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        checks++;
        if ({cmd_ready, busy} !== 2'b01) begin
            failures++;
            $display("FAIL zero_len_cycle1: got ready=%0b busy=%0b, want ready=0 busy=1", cmd_ready, busy);
        end
        @(negedge clk);
        checks++;
        if ({cmd_ready, busy} !== 2'b10) begin
            failures++;
            $display("FAIL zero_len_cycle2: got ready=%0b busy=%0b, want ready=1 busy=0", cmd_ready, busy);
        end
        for (int k = 0; k < 40; k++) begin
            if (ln_start === 1'b1) seen++;
            @(negedge clk);
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL zero_len_no_start: got %0d start cycles, want 0", seen);
        end
    endtask

    task automatic test_back_to_back;
        logic [255:0] w1, w2;
        int sc, sc2;
        set_cmd(16'd10, 16'd20, 16'd5, 16'd640, 32'd100, 32'd150, 32'h11223344, 32'h10000000, 32'h20000000);
        w1 = model(10, 20, 5, 640, 100, 150, 32'h11223344, 32'h10000000, 32'h20000000);
        launch(sc);
        checks++;
        if (sc != 34) begin
            failures++;
            $display("FAIL b2b_first_start: got %0d, want 34", sc);
        end
        set_cmd(16'd300, 16'd100, 16'd17, 16'd1024, 32'd5000, 32'd1000, 32'h55667788, 32'h30000000, 32'h40000000);
        w2 = model(300, 100, 17, 1024, 5000, 1000, 32'h55667788, 32'h30000000, 32'h40000000);
        cmd_valid = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            checks++;
            if ({cmd_ready, obs} !== {1'b0, w1}) begin
                failures++;
                $display("FAIL b2b_hold: cycle %0d got ready=%0b obs=%h, want ready=0 obs=%h",
                         k, cmd_ready, obs, w1);
            end
        end
        ln_done = 1'b1;
        @(negedge clk);
        ln_done = 1'b0;
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_ready_after_done: got %0b, want 1", cmd_ready);
        end
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        sc2 = -1;
        for (int k = 1; k <= 60; k++) begin
            if (k > 1) @(negedge clk);
            if (ln_start === 1'b1) begin
                sc2 = k;
                break;
            end
        end
        checks++;
        if (sc2 != 34) begin
            failures++;
            $display("FAIL b2b_second_start: got %0d, want 34", sc2);
        end
        checks++;
        if (obs !== w2) begin
            failures++;
            $display("FAIL b2b_second_outputs: got %h, want %h", obs, w2);
        end
        finish_span();
    endtask

    task automatic test_reset_mid_div;
        int seen = 0;
        int sc;
        set_cmd(16'd0, 16'd3, 16'd5, 16'd640, 32'd10, 32'd0, 32'hDEADBEEF, 32'h10000000, 32'h20000000);
        @(negedge clk);
        cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (9) @(negedge clk);
        nreset = 1'b0;
        #1;
        checks++;
        if ({cmd_ready, busy, ln_start, obs} !== 259'd0) begin
            failures++;
            $display("FAIL midreset_outputs: got ready=%0b busy=%0b start=%0b obs=%h, want all 0",
                     cmd_ready, busy, ln_start, obs);
        end
        @(negedge clk);
        nreset = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (ln_start === 1'b1 || busy !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL midreset_aborted: got %0d active cycles, want 0", seen);
        end
        set_cmd(16'd10, 16'd20, 16'd5, 16'd640, 32'd100, 32'd150, 32'hAABBCCDD, 32'h10000000, 32'h20000000);
        launch(sc);
        checks++;
        if (sc != 34 || obs !== {32'd10, 32'd5, 32'd0, 32'd0, 32'd100, 32'h10003228, 32'h20003228, 32'hAABBCCDD}) begin
            failures++;
            $display("FAIL midreset_recover: got start_cycle=%0d obs=%h, want 34 and case-1 values", sc, obs);
        end
        finish_span();
    endtask

    task automatic test_random;
        logic [255:0] w;
        int sc, want_sc;
        for (int i = 0; i < 25; i++) begin
            set_cmd(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                    $urandom, $urandom, $urandom, $urandom, $urandom);
            if (i % 4 == 0) x2 = x1 + 16'($urandom_range(0, 5));
            if (i % 5 == 1) z2 = z1 - 32'($urandom_range(0, 40));
            w = model(x1, x2, y, stride, z1, z2, rgbx, fb_base, zb_base);
            want_sc = (x1 == x2) ? -1 : 34;
            checks++;
            if (cmd_ready !== 1'b1) begin
                failures++;
                $display("FAIL rand%0d_ready: got %0b, want 1", i, cmd_ready);
            end
            launch(sc);
            checks++;
            if (sc != want_sc) begin
                failures++;
                $display("FAIL rand%0d_start: got %0d, want %0d", i, sc, want_sc);
            end
            if (want_sc > 0) begin
                checks++;
                if (obs !== w) begin
                    failures++;
                    $display("FAIL rand%0d_outputs: got %h, want %h", i, obs, w);
                end
            end
            finish_span();
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_zero_length();
        test_back_to_back();
        test_reset_mid_div();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hline_setup.md
Name: hline_setup

Overview:
Span setup stage directly upstream of the hline z-buffer line FSM. It accepts one horizontal-span command (endpoints, row, depths, colour, buffer bases) and orders the endpoints. It computes span length, per-pixel z slope, remainder and base addresses using a sequential divider. It then launches the line FSM with a one-cycle start pulse and holds off new commands until that FSM reports done.

Parameters:
DIV_ITERS, 32, divider iterations (one quotient bit per cycle)
BPP_SHIFT, 2, log2 bytes per pixel (32-bit RGBX / 32-bit Z)

Ports:
clk  in  1  system clock
nreset  in  1  reset, asynchronous, active-low
cmd_valid  in  1  command present
cmd_ready  out  1  block idle, command accepted when valid&ready
x1  in  16  endpoint A x (unsigned pixels)
x2  in  16  endpoint B x
y  in  16  row
z1  in  32  endpoint A depth (unsigned)
z2  in  32  endpoint B depth
rgbx  in  32  span colour
fb_base  in  32  framebuffer byte base
zb_base  in  32  z-buffer byte base
stride  in  16  pixels per row (both buffers)
busy  out  1  not IDLE
ln_start  out  1  one-cycle launch pulse to line FSM
ln_fb_addr, ln_zbuff_addr  out  32 each  span start byte addresses
ln_dx  out  32  span length xr-xl
ln_slope  out  32  signed integer z step per pixel
ln_z1  out  32  depth at left endpoint
ln_rem  out  32  |dz| mod dx
ln_err  out  32  initial error term
ln_rgbx  out  32  latched colour
ln_done  in  1  line FSM done (level)

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on nreset. During reset every output and register is 0, except cmd_ready, which is 1 once nreset is high; state = IDLE. Reset mid-operation aborts the command with no ln_start.
- States: IDLE, ADDR, DIV, ISSUE, WAIT.
- IDLE: cmd_ready=1. On valid&ready, latch the command with endpoints ordered: if x1<=x2 then xl=x1, zl=z1, zr=z2; else swap both x and z. Go to ADDR.
- ADDR (1 cycle):
  - ln_dx = xr-xl, zero-extended.
  - dz = zr-zl as 33-bit signed; latch its sign and |dz|.
  - ln_fb_addr = fb_base + ((y*stride + xl) << BPP_SHIFT).
  - ln_zbuff_addr = zb_base + same offset.
  - 16x16 unsigned multiply; sums wrap mod 2^32.
  - ln_z1=zl, ln_rgbx latched, ln_err=0.
  - If dx==0, go to IDLE with no ln_start. Else start the divider and go to DIV.
- DIV: restoring unsigned |dz| / dx, exactly DIV_ITERS cycles.
  - ln_slope = sign ? -q : q, truncated to 32 bits.
  - ln_rem = r (magnitude, 0 <= r < dx).
  - Go to ISSUE.
- ISSUE (1 cycle): ln_start=1. Go to WAIT.
- WAIT: exit to IDLE on ln_done=1. ln_done is ignored in ISSUE; the downstream deasserts done the cycle after start.
- Latency: handshake in cycle 0 -> ADDR cycle 1 -> DIV cycles 2..33 -> ln_start in cycle 34. For dx==0, cmd_ready is high again in cycle 2.
- All ln_* data outputs are stable from ISSUE through WAIT exit, and change only in ADDR/DIV.
- cmd_valid outside IDLE is ignored (no queueing); inputs are sampled only on the handshake.
- ln_done high while in IDLE/ADDR/DIV has no effect.
- Divide-by-zero is unreachable (dx==0 is filtered in ADDR).

Decomposition:
- Package hline_pkg: state encoding localparams, DIV_ITERS, BPP_SHIFT.
- One sub-module, hline_div_seq: 32/32 restoring divider with start/done handshake and quotient/remainder outputs. The top owns the FSM, ordering, address arithmetic and sign handling.

Test Plan:
1. x1=10,x2=20,y=5,stride=640,z1=100,z2=150,fb_base=0x10000000,zb_base=0x20000000 -> ln_dx=10, ln_slope=5, ln_rem=0, ln_z1=100, ln_fb_addr=0x10003228, ln_zbuff_addr=0x20003228, ln_start exactly in cycle 34.
2. Same span reversed (x1=20,z1=150,x2=10,z2=100) -> outputs identical to case 1.
3. x1=0,x2=3,z1=10,z2=0 -> ln_dx=3, ln_slope=0xFFFFFFFD, ln_rem=1.
4. x1=x2=7 -> no ln_start ever; cmd_ready=1 in cycle 2; busy low from cycle 2.
5. Second cmd_valid held during WAIT, ln_done asserted 100 cycles after ln_start -> cmd_ready low, ln_* stable throughout; second command accepted the cycle after ln_done.
6. nreset pulsed low mid-DIV (cycle 10) -> all outputs 0 immediately, no ln_start; after release, a new case-1 command completes normally.
